// File: rtl/ck_core_pkg.sv
// Shared CK_riscv core constants: widths, control-bundle field positions and
// the pipeline-slot state encoding.
package ck_core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned CTRL_W = 11;

  // Bit positions inside the packed control bundle
  localparam int unsigned CTRL_REG_WR    = 10;
  localparam int unsigned CTRL_MEM2REG   = 9;
  localparam int unsigned CTRL_MEM_WR    = 8;
  localparam int unsigned CTRL_MEM_RD    = 7;
  localparam int unsigned CTRL_MEM_OP_HI = 6;
  localparam int unsigned CTRL_MEM_OP_LO = 4;
  localparam int unsigned CTRL_ALU_OP_HI = 3;
  localparam int unsigned CTRL_ALU_OP_LO = 2;
  localparam int unsigned CTRL_DATA1_SEL = 1;

  // Bit 0 = main valid, bit 1 = skid valid
  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'b00,
    SLOT_BUSY  = 2'b01,
    SLOT_FULL  = 2'b11
  } slot_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// Generic valid/ready pipeline slot with a main entry, a one-deep skid entry
// and a synchronous flush that drops everything held.
module pipe_skid_slot
  import ck_core_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  slot_state_e   state_q, state_d;
  logic [PW-1:0] main_q, skid_q;
  logic          in_ready_q;
  logic          accept, drain;
  logic          load_main, load_skid, main_from_skid;

  assign accept    = in_valid & in_ready_q;
  assign drain     = state_q[0] & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign out_data  = main_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= SLOT_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SLOT_FULL);
    end
  end

  // Next state and payload enables; flush overrides every load
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        if (accept) begin
          state_d   = SLOT_BUSY;
          load_main = 1'b1;
        end
      end
      SLOT_BUSY: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = SLOT_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (drain) begin
          state_d        = SLOT_BUSY;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (flush) begin
      state_d        = SLOT_EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_skid) main_q <= skid_q;
      else if (load_main) main_q <= in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage: packs decode outputs into a skid slot, gates control
// with valid, counts stalled cycles and optionally bypasses rs data.
module id_ex_stage #(
  parameter int unsigned XLEN        = ck_core_pkg::XLEN,
  parameter int unsigned CTRL_W      = ck_core_pkg::CTRL_W,
  parameter int unsigned ALUC_W      = 4,
  parameter int unsigned RA_W        = ck_core_pkg::RA_W,
  parameter int unsigned RS_DATA_REG = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [ALUC_W-1:0] aluc_in,
  input  logic [RA_W-1:0]   rd_addr_in,
  input  logic [RA_W-1:0]   rs1_addr_in,
  input  logic [RA_W-1:0]   rs2_addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [XLEN-1:0]   rs1_data_out,
  output logic [XLEN-1:0]   rs2_data_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [ALUC_W-1:0] aluc_out,
  output logic [RA_W-1:0]   rd_addr_out,
  output logic [RA_W-1:0]   rs1_addr_out,
  output logic [RA_W-1:0]   rs2_addr_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PW = CTRL_W + ALUC_W + 3 * RA_W + 3 * XLEN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]     slot_in, slot_out;
  logic [CTRL_W-1:0] slot_ctrl;
  logic [XLEN-1:0]   slot_rs1, slot_rs2;
  logic [CNT_W-1:0]  stall_q;

  // rs data always rides in the payload; with the bypass selected those flops
  // have no load and are pruned in synthesis.
  assign slot_in = {ctrl_in, aluc_in, rd_addr_in, rs1_addr_in, rs2_addr_in,
                    imm_in, rs1_data_in, rs2_data_in};

  pipe_skid_slot #(.PW(PW)) u_slot (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (slot_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (slot_out)
  );

  assign {slot_ctrl, aluc_out, rd_addr_out, rs1_addr_out, rs2_addr_out,
          imm_out, slot_rs1, slot_rs2} = slot_out;

  // Stale payload may linger after a flush; gating keeps reg_wr/mem_wr quiet
  assign ctrl_out     = out_valid ? slot_ctrl : '0;
  assign rs1_data_out = (RS_DATA_REG != 0) ? slot_rs1 : rs1_data_in;
  assign rs2_data_out = (RS_DATA_REG != 0) ? slot_rs2 : rs2_data_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: streaming, backpressure,
// flush, async reset, counter saturation and rs-data bypass.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_valid2, flush, out_ready, out_ready2;
  logic [10:0] ctrl_in;
  logic [31:0] rs1_data_in, rs2_data_in, imm_in;
  logic [3:0]  aluc_in;
  logic [4:0]  rd_addr_in, rs1_addr_in, rs2_addr_in;

  logic        in_ready, out_valid;
  logic [10:0] ctrl_out;
  logic [31:0] rs1_data_out, rs2_data_out, imm_out;
  logic [3:0]  aluc_out;
  logic [4:0]  rd_addr_out, rs1_addr_out, rs2_addr_out;
  logic [15:0] stall_cnt;

  logic        in_ready2, out_valid2;
  logic [10:0] ctrl_out2;
  logic [31:0] rs1_data_out2, rs2_data_out2, imm_out2;
  logic [3:0]  aluc_out2;
  logic [4:0]  rd_addr_out2, rs1_addr_out2, rs2_addr_out2;
  logic [2:0]  stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .ctrl_in(ctrl_in), .rs1_data_in(rs1_data_in),
    .rs2_data_in(rs2_data_in), .imm_in(imm_in), .aluc_in(aluc_in),
    .rd_addr_in(rd_addr_in), .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
    .aluc_out(aluc_out), .rd_addr_out(rd_addr_out), .rs1_addr_out(rs1_addr_out),
    .rs2_addr_out(rs2_addr_out), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(3), .RS_DATA_REG(0)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
    .flush(flush), .ctrl_in(ctrl_in), .rs1_data_in(rs1_data_in),
    .rs2_data_in(rs2_data_in), .imm_in(imm_in), .aluc_in(aluc_in),
    .rd_addr_in(rd_addr_in), .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
    .out_valid(out_valid2), .out_ready(out_ready2), .ctrl_out(ctrl_out2),
    .rs1_data_out(rs1_data_out2), .rs2_data_out(rs2_data_out2), .imm_out(imm_out2),
    .aluc_out(aluc_out2), .rd_addr_out(rd_addr_out2), .rs1_addr_out(rs1_addr_out2),
    .rs2_addr_out(rs2_addr_out2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction whose fields are all derived from rd
  task automatic drive(input logic v, input logic [4:0] rd);
    in_valid    = v;
    rd_addr_in  = rd;
    ctrl_in     = 11'h400 | 11'(rd);
    imm_in      = 32'h1000_0000 | 32'(rd);
    aluc_in     = rd[3:0];
    rs1_addr_in = rd + 5'd1;
    rs2_addr_in = rd + 5'd2;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b1; out_ready2 = 1'b0;
    in_valid2 = 1'b0; rs1_data_in = 32'h0; rs2_data_in = 32'h0;
    drive(1'b0, 5'd0);

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ctrl", 64'(ctrl_out), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rstn = 1'b1;

    // Streaming rd 1..8 with EX always ready
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i));
      step();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_rd", 64'(rd_addr_out), 64'(i));
      chk("stream_ctrl", 64'(ctrl_out), 64'(11'h400 | 11'(i)));
      chk("stream_imm", 64'(imm_out), 64'(32'h1000_0000 | 32'(i)));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, 5'd0);
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: A (rd 3) then B (rd 4) with EX stalled
    out_ready = 1'b0;
    drive(1'b1, 5'd3);
    step();
    chk("bp_busy_valid", 64'(out_valid), 64'd1);
    chk("bp_busy_rd", 64'(rd_addr_out), 64'd3);
    chk("bp_busy_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 5'd4);
    step();
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_full_rd", 64'(rd_addr_out), 64'd3);
    chk("bp_stall1", 64'(stall_cnt), 64'd1);
    drive(1'b0, 5'd0);
    step();
    chk("bp_hold_rd", 64'(rd_addr_out), 64'd3);
    chk("bp_stall2", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    step();
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_rd", 64'(rd_addr_out), 64'd4);
    chk("bp_b_imm", 64'(imm_out), 64'h1000_0004);
    chk("bp_b_ready", 64'(in_ready), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_stall_final", 64'(stall_cnt), 64'd2);

    // Flush while FULL, with C (rd 7) offered
    out_ready = 1'b0;
    drive(1'b1, 5'd5);
    step();
    drive(1'b1, 5'd6);
    step();
    chk("fl_full_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 5'd7);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(ctrl_out), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_stall", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    step();
    chk("fl_no_c", 64'(out_valid), 64'd0);

    // Flush in BUSY discards the instruction accepted in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 5'd8);
    step();
    flush = 1'b1;
    drive(1'b1, 5'd9);
    step();
    flush = 1'b0;
    drive(1'b0, 5'd0);
    chk("flb_valid", 64'(out_valid), 64'd0);
    step();
    chk("flb_no_accept", 64'(out_valid), 64'd0);
    chk("flb_stall", 64'(stall_cnt), 64'd5);

    // Flush together with drain
    out_ready = 1'b1;
    drive(1'b1, 5'd10);
    step();
    drive(1'b0, 5'd0);
    flush = 1'b1;
    chk("fd_present", 64'(rd_addr_out), 64'd10);
    chk("fd_ctrl", 64'(ctrl_out), 64'h40A);
    step();
    flush = 1'b0;
    chk("fd_gone", 64'(out_valid), 64'd0);
    chk("fd_stall", 64'(stall_cnt), 64'd5);

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0;
    drive(1'b1, 5'd11);
    step();
    drive(1'b1, 5'd12);
    step();
    drive(1'b0, 5'd0);
    chk("ar_pre_ready", 64'(in_ready), 64'd0);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ctrl", 64'(ctrl_out), 64'd0);
    chk("ar_imm", 64'(imm_out), 64'd0);
    chk("ar_stall", 64'(stall_cnt), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    step();
    rstn = 1'b1;
    out_ready = 1'b1;

    // Three-bit counter saturates after ten stalled cycles
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    repeat (10) step();
    chk("sat_stall", 64'(stall_cnt2), 64'd7);
    chk("sat_valid", 64'(out_valid2), 64'd1);

    // rs data bypass follows the input in the same cycle
    out_ready2 = 1'b1;
    rs1_data_in = 32'hDEAD_BEEF;
    rs2_data_in = 32'h1234_5678;
    #1;
    chk("byp_rs1", 64'(rs1_data_out2), 64'hDEAD_BEEF);
    chk("byp_rs2", 64'(rs2_data_out2), 64'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      rs1_data_in = 32'hA000_0000 | 32'(i);
      step();
      chk("byp_ready", 64'(in_ready2), 64'd1);
      chk("byp_track", 64'(rs1_data_out2), 64'(32'hA000_0000 | 32'(i)));
    end
    in_valid2 = 1'b0;
    chk("sat_hold", 64'(stall_cnt2), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised ID→EX pipeline stage for the CK_riscv core.
- Replaces the fixed free-running stage register with a valid/ready pipeline slot that has a 2-entry skid buffer.
- Adds synchronous flush (bubble insertion) and a saturating stall-cycle counter.
- Sits between the decode/register-read logic and the EX ALU/forwarding unit.

Parameters:
- XLEN, 32, width of the rs1/rs2 data and immediate fields.
- CTRL_W, 11, packed control bundle width: {reg_wr, mem2reg_sel, mem_wr, mem_rd, mem_op[2:0], exAlu_op[1:0], exAlu_data1_sel, spare}.
- ALUC_W, 4, ALU control field width.
- RA_W, 5, register address width.
- RS_DATA_REG, 1, selects rs data path. 1: rs data travels through main/skid with the rest of the payload. 0: rs data is a combinational passthrough for a synchronous register file.
- CNT_W, 16, stall counter width.

Ports:
- clk, input, 1, core clock.
- rstn, input, 1, asynchronous active-low reset.
- in_valid, input, 1, decode holds a valid instruction.
- in_ready, output, 1, stage can accept; registered.
- flush, input, 1, synchronous kill of all held entries.
- ctrl_in, input, CTRL_W, decoded control bundle.
- rs1_data_in, input, XLEN, source 1 data.
- rs2_data_in, input, XLEN, source 2 data.
- imm_in, input, XLEN, immediate.
- aluc_in, input, ALUC_W, ALU control.
- rd_addr_in, input, RA_W, write-back address.
- rs1_addr_in, input, RA_W, source 1 address.
- rs2_addr_in, input, RA_W, source 2 address.
- out_valid, output, 1, EX slot valid.
- out_ready, input, 1, EX consumes the slot.
- ctrl_out, output, CTRL_W, control bundle, forced to zero when out_valid=0.
- rs1_data_out, output, XLEN, source 1 data to EX.
- rs2_data_out, output, XLEN, source 2 data to EX.
- imm_out, output, XLEN, immediate to EX.
- aluc_out, output, ALUC_W, ALU control to EX.
- rd_addr_out, output, RA_W, write-back address to EX.
- rs1_addr_out, output, RA_W, source 1 address to EX.
- rs2_addr_out, output, RA_W, source 2 address to EX.
- stall_cnt, output, CNT_W, saturating count of stalled cycles.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each with a valid bit and a full payload.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !skid_valid, taken from a flop. out_valid = main_valid.
- State machine:
  - EMPTY (main invalid, skid invalid)
  - BUSY (main valid, skid invalid)
  - FULL (main valid, skid valid)
- Transitions:
  - EMPTY: accept → BUSY, main loaded; otherwise stay EMPTY.
  - BUSY: accept & drain → BUSY, main reloaded with new input. accept & !drain → FULL, skid loaded, main held. !accept & drain → EMPTY. Neither → hold.
  - FULL: in_ready=0, so no accept. drain → BUSY, main ← skid. Otherwise hold.
- Latency: 1 cycle from accept to out_valid when the stage was EMPTY or draining. Throughput is 1 instruction/cycle while out_ready=1.
- Flush (highest priority):
  - Next cycle: main_valid=0, skid_valid=0, in_ready=1.
  - An accept in the flush cycle is discarded.
  - Payload registers may keep stale data, but ctrl_out reads 0 because it is gated by main_valid, so no spurious reg_wr or mem_wr.
- Simultaneous flush & drain: the drain completes (EX sees it this cycle); nothing remains afterwards.
- RS_DATA_REG=0:
  - rs1_data_out = rs1_data_in and rs2_data_out = rs2_data_in, combinational.
  - Legal only if out_ready is tied to 1; the bench checks in_ready stays 1.
- Stall counter:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Unaffected by flush; cleared only by rstn.
- Reset (async, rstn=0), applied immediately:
  - main/skid valid=0, all payload flops 0, stall_cnt=0.
  - Outputs: out_valid=0, ctrl_out=0, in_ready=1.
  - Reset mid-transfer loses both entries without any output glitch beyond going to zero.
- No X propagation: payload registers load only on their enable (main on accept-to-main or skid-to-main, skid on accept-to-skid).

Decomposition:
- Shared package ck_core_pkg:
  - CTRL_W and bit-index constants for each control field (CTRL_REG_WR=10, CTRL_MEM2REG=9, CTRL_MEM_WR=8, CTRL_MEM_RD=7, CTRL_MEM_OP=6:4, CTRL_ALU_OP=3:2, CTRL_DATA1_SEL=1).
  - Width constants XLEN, RA_W.
  - The state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b11).
- One natural sub-module: pipe_skid_slot, a generic payload-width 2-entry skid buffer with flush. id_ex_stage packs and unpacks fields around it and owns the stall counter and the RS_DATA_REG bypass.

Test Plan:
- Reset then stream: rstn low 3 cycles, then in_valid=1 with rd_addr_in=1..8 on consecutive cycles, out_ready=1. Each rd_addr_out appears 1 cycle after its accept, in order. in_ready stays 1. stall_cnt=0.
- Backpressure: out_ready=0 while sending A (rd=3) then B (rd=4). State goes BUSY then FULL and in_ready drops to 0. Releasing out_ready delivers A then B, no loss or duplication. stall_cnt equals the number of cycles with out_ready low and out_valid=1.
- Flush in FULL: hold A, B, assert flush 1 cycle with in_valid=1 (C). Next cycle out_valid=0, ctrl_out=0, in_ready=1. C never appears.
- Flush with drain: out_valid=1, out_ready=1, flush=1 together. That entry is consumed that cycle and out_valid=0 next cycle.
- Async reset mid-FULL: rstn pulse between clock edges. out_valid, ctrl_out, imm_out, stall_cnt go 0 immediately; in_ready=1.
- Saturation and bypass: with CNT_W=3, stall 10 cycles → stall_cnt=7. With RS_DATA_REG=0, rs1_data_out tracks rs1_data_in 0xDEADBEEF in the same cycle.
